alignment_replay: RTL and testbench
===================================

# alignment_replay

Sequential decoder for the forward-ordered alignment edit stream produced by the team's Smith-Waterman aligner. It consumes one edit op per handshake against a latched 2-bit-encoded reference sequence and regenerates the aligned query bases as a stream. It also independently recomputes the Levenshtein distance and alignment score, so the bench and downstream logic can cross-check the aligner's traceback.

## Interface
- SEQ1_LENGTH, 16: reference length in bits (8 bases).
- SEQ2_LENGTH, 14: maximum query length in bits (7 bases).
- MATCH_REWARD, 2 / MISMATCH_PENALTY, 1 / GAP_PENALTY, 0: score increments.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  latches ref_seq/ref_start; honored only in IDLE or DONE.
- ref_seq  in  [0:SEQ1_LENGTH-1]  reference; base k = {ref_seq[2k], ref_seq[2k+1]}, A=00 C=01 G=10 T=11.
- ref_start  in  3  0-based base index where the alignment begins.
- op_valid / op_ready  in / out  1  edit-op handshake.
- op_code  in  2  00 MATCH, 01 MISMATCH, 10 INSERT (query-only base), 11 DELETE (reference-only base).
- op_base  in  2  query base for MISMATCH/INSERT; ignored otherwise.
- op_last  in  1  marks final op.
- q_valid / q_ready  out / in  1  query-base output handshake.
- q_base  out  2  regenerated query base.
- busy, done, err  out  1 each  status.
- ldistance  out  8  mismatch + gap count; score  out  8  recomputed score; q_len  out  4  bases emitted.

## Operation
- States: IDLE, RUN, DRAIN, DONE. IDLE->RUN and DONE->RUN on start: ptr<=ref_start; ldistance, score, q_len, err, done cleared. start in RUN/DRAIN ignored.
- op_ready = (state==RUN) && (!q_valid || q_ready); one-entry output register, so one op per cycle under no backpressure.
- On op accept:
  - MATCH: emit ref[ptr]; ptr+1; score+MATCH_REWARD.
  - MISMATCH: emit op_base; ptr+1; ldistance+1; score+MISMATCH_PENALTY.
  - INSERT: emit op_base; ptr unchanged; ldistance+1; score+GAP_PENALTY.
  - DELETE: no emit; ptr+1; ldistance+1; score+GAP_PENALTY.
- Ref overrun: an op that consumes a reference base when ptr==SEQ1_LENGTH/2 sets err; the op is consumed without emission or counter update; go to DRAIN.
- Query overflow: an emitting op when q_len==SEQ2_LENGTH/2 sets err with the same handling.
- op_last accepted without error: go to DRAIN. DRAIN->DONE once q_valid==0, or in the same cycle the final q handshake completes.
- done is held high in DONE. busy is high in RUN and DRAIN.
- ldistance and score saturate at 255.
- q_len increments at the edge where the op is accepted, not at the output handshake.

## Timing
- Reset values: op_ready 0, q_valid 0, q_base 00, busy 0, done 0, err 0, ldistance 0, score 0, q_len 0, state IDLE.
- Reset is asynchronous: outputs take reset values immediately, including mid-stream. A pending q beat is dropped.
- start sampled at edge N: busy=1 and op_ready=1 from N+1.
- Op accepted at edge N: q_valid/q_base valid from N+1; counters updated at N.
- q_base and q_valid are held stable while q_valid && !q_ready.
- Simultaneous q handshake and op accept in the same cycle: the register is reloaded, with no bubble.
- done rises one cycle after the DRAIN exit condition.

## Configuration
- ALN_MISMATCH_CHECK_EN defined: a MISMATCH whose op_base equals ref[ptr] sets err. The op is still fully processed, emitted and counted, and the stream continues.
- ALN_MISMATCH_CHECK_EN undefined: no base comparison on MISMATCH, and err arises only from overrun or overflow.

## Test plan
- Plain match run: ref_seq=16'h1B1B (ACGTACGT), ref_start=0, ops MATCH×4 with last on the 4th, q_ready=1 -> q_base 00,01,10,11 on consecutive cycles; score 8, ldistance 0, q_len 4, done=1, err=0.
- Mixed edits: same ref, ref_start=2, ops MATCH, MISMATCH(00), INSERT(01), DELETE, MATCH(last) -> q_base 10,00,01,01; score 5, ldistance 3, q_len 4, done=1.
- Backpressure: hold q_ready=0 for 3 cycles after the first emission -> q_base stable, op_ready=0, counters frozen. After release, the stream resumes with no lost or duplicated base.
- Ref overrun: ref_start=7, ops MATCH, MATCH -> q_base 11 only; err=1, score 2, done=1 after drain.
- Mismatch check: ref_start=0, MISMATCH(00, last) -> with ALN_MISMATCH_CHECK_EN, err=1; without it, err=0. In both cases ldistance 1 and q_base 00.
- Reset mid-stream: assert rst while q_valid=1 in RUN -> all outputs go to reset values immediately. The next start with fresh ops reproduces the plain-match-run results exactly.

Source files
------------

// File: rtl/alignment_replay_if.sv
// Handshake and status bundle between an edit-op source / query sink and alignment_replay.
interface alignment_replay_if #(
    parameter int unsigned SEQ1_LENGTH = 16,
    parameter int unsigned SEQ2_LENGTH = 14
);
    logic                   start;
    logic [0:SEQ1_LENGTH-1] ref_seq;
    logic [2:0]             ref_start;

    logic                   op_valid;
    logic                   op_ready;
    logic [1:0]             op_code;
    logic [1:0]             op_base;
    logic                   op_last;

    logic                   q_valid;
    logic                   q_ready;
    logic [1:0]             q_base;

    logic                   busy;
    logic                   done;
    logic                   err;
    logic [7:0]             ldistance;
    logic [7:0]             score;
    logic [3:0]             q_len;

    modport master (
        output start, ref_seq, ref_start,
        output op_valid, op_code, op_base, op_last,
        input  op_ready,
        input  q_valid, q_base,
        output q_ready,
        input  busy, done, err, ldistance, score, q_len
    );

    modport slave (
        input  start, ref_seq, ref_start,
        input  op_valid, op_code, op_base, op_last,
        output op_ready,
        output q_valid, q_base,
        input  q_ready,
        output busy, done, err, ldistance, score, q_len
    );
endinterface

// File: rtl/alignment_replay.sv
// Replays a forward-ordered alignment edit stream against a latched reference, regenerating query bases
// and recomputing edit distance / score. Optional macro ALN_MISMATCH_CHECK_EN flags MISMATCH ops whose base equals the reference.
module alignment_replay #(
    parameter int unsigned SEQ1_LENGTH      = 16,
    parameter int unsigned SEQ2_LENGTH      = 14,
    parameter int unsigned MATCH_REWARD     = 2,
    parameter int unsigned MISMATCH_PENALTY = 1,
    parameter int unsigned GAP_PENALTY      = 0
) (
    input  logic               clk,
    input  logic               rst,
    alignment_replay_if.slave  bus
);
    localparam int unsigned REF_BASES = SEQ1_LENGTH / 2;
    localparam int unsigned Q_BASES   = SEQ2_LENGTH / 2;
    localparam int unsigned PTR_W     = $clog2(REF_BASES + 1);
    localparam int unsigned IDX_W     = $clog2(SEQ1_LENGTH);
    localparam int unsigned QLEN_W    = 4;
    localparam int unsigned CNT_W     = 8;

    localparam logic [1:0] OP_MATCH    = 2'b00;
    localparam logic [1:0] OP_MISMATCH = 2'b01;
    localparam logic [1:0] OP_INSERT   = 2'b10;
    localparam logic [1:0] OP_DELETE   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [PTR_W-1:0]   ptr;
    logic [CNT_W-1:0]   ldistance;
    logic [CNT_W-1:0]   score;
    logic [QLEN_W-1:0]  q_len;
    logic               err;
    logic               q_valid;
    logic [1:0]         q_base;

    logic               op_ready_c;
    logic               busy_c;
    logic               done_c;
    logic               start_ok_c;
    logic               accept_c;
    logic               consumes_c;
    logic               emits_c;
    logic               overrun_c;
    logic               overflow_c;
    logic               fault_c;
    logic               mm_err_c;
    logic [1:0]         ref_base_c;
    logic [1:0]         emit_base_c;
    logic [CNT_W-1:0]   ld_inc_c;
    logic [CNT_W-1:0]   sc_inc_c;
    logic [IDX_W-1:0]   ref_idx_hi_c;
    logic [IDX_W-1:0]   ref_idx_lo_c;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    // Reference base under ptr; ptr==REF_BASES wraps here but is never used (overrun path).
    assign ref_idx_hi_c = IDX_W'({ptr, 1'b0});
    assign ref_idx_lo_c = IDX_W'({ptr, 1'b1});
    assign ref_base_c   = {bus.ref_seq[ref_idx_hi_c], bus.ref_seq[ref_idx_lo_c]};

    assign start_ok_c = bus.start && ((state == ST_IDLE) || (state == ST_DONE));
    assign accept_c   = bus.op_valid && op_ready_c;

    // Per-op decode of reference consumption, emission and counter increments.
    always_comb begin
        consumes_c  = 1'b1;
        emits_c     = 1'b1;
        emit_base_c = bus.op_base;
        ld_inc_c    = CNT_W'(1);
        sc_inc_c    = CNT_W'(GAP_PENALTY);
        case (bus.op_code)
            OP_MATCH: begin
                emit_base_c = ref_base_c;
                ld_inc_c    = '0;
                sc_inc_c    = CNT_W'(MATCH_REWARD);
            end
            OP_MISMATCH: begin
                sc_inc_c    = CNT_W'(MISMATCH_PENALTY);
            end
            OP_INSERT: begin
                consumes_c  = 1'b0;
            end
            OP_DELETE: begin
                emits_c     = 1'b0;
            end
            default: begin
                emits_c     = 1'b0;
            end
        endcase
    end

    assign overrun_c  = consumes_c && (ptr == PTR_W'(REF_BASES));
    assign overflow_c = emits_c && (q_len == QLEN_W'(Q_BASES));
    assign fault_c    = overrun_c || overflow_c;

`ifdef ALN_MISMATCH_CHECK_EN
    assign mm_err_c = (bus.op_code == OP_MISMATCH) && (bus.op_base == ref_base_c);
`else
    assign mm_err_c = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start_ok_c) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (accept_c && (fault_c || bus.op_last)) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!q_valid || bus.q_ready) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (start_ok_c) state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        op_ready_c = 1'b0;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        case (state)
            ST_RUN: begin
                op_ready_c = !q_valid || bus.q_ready;
                busy_c     = 1'b1;
            end
            ST_DRAIN: begin
                busy_c     = 1'b1;
            end
            ST_DONE: begin
                done_c     = 1'b1;
            end
            default: begin
                op_ready_c = 1'b0;
            end
        endcase
    end

    // Reference pointer, counters and the one-entry query output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            ldistance <= '0;
            score     <= '0;
            q_len     <= '0;
            err       <= 1'b0;
            q_valid   <= 1'b0;
            q_base    <= 2'b00;
        end else begin
            if (q_valid && bus.q_ready) begin
                q_valid <= 1'b0;
            end
            if (start_ok_c) begin
                ptr       <= PTR_W'(bus.ref_start);
                ldistance <= '0;
                score     <= '0;
                q_len     <= '0;
                err       <= 1'b0;
            end else if (accept_c) begin
                if (fault_c) begin
                    err <= 1'b1;
                end else begin
                    if (consumes_c) begin
                        ptr <= ptr + PTR_W'(1);
                    end
                    if (emits_c) begin
                        q_valid <= 1'b1;
                        q_base  <= emit_base_c;
                        q_len   <= q_len + QLEN_W'(1);
                    end
                    ldistance <= sat_add(ldistance, ld_inc_c);
                    score     <= sat_add(score, sc_inc_c);
                    if (mm_err_c) begin
                        err <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.op_ready  = op_ready_c;
    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.q_valid   = q_valid;
    assign bus.q_base    = q_base;
    assign bus.err       = err;
    assign bus.ldistance = ldistance;
    assign bus.score     = score;
    assign bus.q_len     = q_len;

endmodule

// File: tb/tb_alignment_replay.sv
// Directed, table-driven bench for alignment_replay with hand-computed per-cycle expectations.
module tb_alignment_replay;
    localparam logic [1:0] M = 2'b00;
    localparam logic [1:0] X = 2'b01;
    localparam logic [1:0] I = 2'b10;
    localparam logic [1:0] D = 2'b11;
    localparam int NVEC = 34;

`ifdef ALN_MISMATCH_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    typedef struct packed {
        logic       op_ready;
        logic       q_valid;
        logic [1:0] q_base;
        logic       busy;
        logic       done;
        logic       err;
        logic [7:0] ld;
        logic [7:0] score;
        logic [3:0] q_len;
    } out_t;

    typedef struct packed {
        logic       start;
        logic [2:0] rs;
        logic       ov;
        logic [1:0] code;
        logic [1:0] base;
        logic       last;
        logic       qr;
        out_t       exp;
    } vec_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    vec_t vecs [NVEC];

    alignment_replay_if #(.SEQ1_LENGTH(16), .SEQ2_LENGTH(14)) intf ();

    alignment_replay #(
        .SEQ1_LENGTH(16), .SEQ2_LENGTH(14),
        .MATCH_REWARD(2), .MISMATCH_PENALTY(1), .GAP_PENALTY(0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (intf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic s, input logic [2:0] rs, input logic ov, input logic [1:0] c, input logic [1:0] b,
        input logic l, input logic qr,
        input logic ordy, input logic qv, input logic [1:0] qb, input logic bz, input logic dn, input logic er,
        input logic [7:0] ld, input logic [7:0] sc, input logic [3:0] ql);
        vec_t v;
        v.start = s; v.rs = rs; v.ov = ov; v.code = c; v.base = b; v.last = l; v.qr = qr;
        v.exp.op_ready = ordy; v.exp.q_valid = qv; v.exp.q_base = qb; v.exp.busy = bz;
        v.exp.done = dn; v.exp.err = er; v.exp.ld = ld; v.exp.score = sc; v.exp.q_len = ql;
        return v;
    endfunction

    function automatic out_t get_out();
        out_t o;
        o.op_ready = intf.op_ready; o.q_valid = intf.q_valid; o.q_base = intf.q_base;
        o.busy = intf.busy; o.done = intf.done; o.err = intf.err;
        o.ld = intf.ldistance; o.score = intf.score; o.q_len = intf.q_len;
        return o;
    endfunction

    function automatic string fmt(input out_t o);
        return $sformatf("ordy=%b qv=%b qb=%b busy=%b done=%b err=%b ld=%0d sc=%0d ql=%0d",
                         o.op_ready, o.q_valid, o.q_base, o.busy, o.done, o.err, o.ld, o.score, o.q_len);
    endfunction

    task automatic check_out(input string name, input out_t act, input out_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {%s} want {%s}", name, fmt(act), fmt(exp));
        end
    endtask

    task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [2:0] rs, input logic ov, input logic [1:0] c,
                         input logic [1:0] b, input logic l, input logic qr);
        @(negedge clk);
        intf.start = s; intf.ref_start = rs; intf.op_valid = ov; intf.op_code = c;
        intf.op_base = b; intf.op_last = l; intf.q_ready = qr;
    endtask

    task automatic apply_range(input int lo, input int hi, input string tag);
        out_t act;
        for (int k = lo; k <= hi; k++) begin
            drive(vecs[k].start, vecs[k].rs, vecs[k].ov, vecs[k].code, vecs[k].base, vecs[k].last, vecs[k].qr);
            #1;
            act = get_out();
            if (!vecs[k].exp.q_valid) act.q_base = vecs[k].exp.q_base;
            check_out($sformatf("%s_vec%0d", tag, k), act, vecs[k].exp);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        //               s rs ov c  b     l qr   ordy qv qb    bz dn er  ld sc ql
        vecs[0]  = mk(1, 0, 0, M, 2'b00, 0, 1,  0, 0, 2'b00, 0, 0, 0,  0, 0, 0);
        vecs[1]  = mk(0, 0, 1, M, 2'b00, 0, 1,  1, 0, 2'b00, 1, 0, 0,  0, 0, 0);
        vecs[2]  = mk(0, 0, 1, M, 2'b00, 0, 1,  1, 1, 2'b00, 1, 0, 0,  0, 2, 1);
        vecs[3]  = mk(0, 0, 1, M, 2'b00, 0, 1,  1, 1, 2'b01, 1, 0, 0,  0, 4, 2);
        vecs[4]  = mk(0, 0, 1, M, 2'b00, 1, 1,  1, 1, 2'b10, 1, 0, 0,  0, 6, 3);
        vecs[5]  = mk(0, 0, 0, M, 2'b00, 0, 1,  0, 1, 2'b11, 1, 0, 0,  0, 8, 4);
        vecs[6]  = mk(0, 0, 0, M, 2'b00, 0, 1,  0, 0, 2'b00, 0, 1, 0,  0, 8, 4);
        // mixed edits from base 2
        vecs[7]  = mk(1, 2, 0, M, 2'b00, 0, 1,  0, 0, 2'b00, 0, 1, 0,  0, 8, 4);
        vecs[8]  = mk(0, 2, 1, M, 2'b00, 0, 1,  1, 0, 2'b00, 1, 0, 0,  0, 0, 0);
        vecs[9]  = mk(0, 2, 1, X, 2'b00, 0, 1,  1, 1, 2'b10, 1, 0, 0,  0, 2, 1);
        vecs[10] = mk(0, 2, 1, I, 2'b01, 0, 1,  1, 1, 2'b00, 1, 0, 0,  1, 3, 2);
        vecs[11] = mk(0, 2, 1, D, 2'b00, 0, 1,  1, 1, 2'b01, 1, 0, 0,  2, 3, 3);
        vecs[12] = mk(0, 2, 1, M, 2'b00, 1, 1,  1, 0, 2'b00, 1, 0, 0,  3, 3, 3);
        vecs[13] = mk(0, 2, 0, M, 2'b00, 0, 1,  0, 1, 2'b01, 1, 0, 0,  3, 5, 4);
        vecs[14] = mk(0, 2, 0, M, 2'b00, 0, 1,  0, 0, 2'b00, 0, 1, 0,  3, 5, 4);
        // backpressure: q_ready low for three cycles after the first emission
        vecs[15] = mk(1, 0, 0, M, 2'b00, 0, 1,  0, 0, 2'b00, 0, 1, 0,  3, 5, 4);
        vecs[16] = mk(0, 0, 1, M, 2'b00, 0, 1,  1, 0, 2'b00, 1, 0, 0,  0, 0, 0);
        vecs[17] = mk(0, 0, 1, M, 2'b00, 0, 0,  0, 1, 2'b00, 1, 0, 0,  0, 2, 1);
        vecs[18] = mk(0, 0, 1, M, 2'b00, 0, 0,  0, 1, 2'b00, 1, 0, 0,  0, 2, 1);
        vecs[19] = mk(0, 0, 1, M, 2'b00, 0, 0,  0, 1, 2'b00, 1, 0, 0,  0, 2, 1);
        vecs[20] = mk(0, 0, 1, M, 2'b00, 0, 1,  1, 1, 2'b00, 1, 0, 0,  0, 2, 1);
        vecs[21] = mk(0, 0, 1, M, 2'b00, 1, 1,  1, 1, 2'b01, 1, 0, 0,  0, 4, 2);
        vecs[22] = mk(0, 0, 0, M, 2'b00, 0, 0,  0, 1, 2'b10, 1, 0, 0,  0, 6, 3);
        vecs[23] = mk(0, 0, 0, M, 2'b00, 0, 1,  0, 1, 2'b10, 1, 0, 0,  0, 6, 3);
        vecs[24] = mk(0, 0, 0, M, 2'b00, 0, 1,  0, 0, 2'b00, 0, 1, 0,  0, 6, 3);
        // reference overrun from base 7
        vecs[25] = mk(1, 7, 0, M, 2'b00, 0, 1,  0, 0, 2'b00, 0, 1, 0,  0, 6, 3);
        vecs[26] = mk(0, 7, 1, M, 2'b00, 0, 1,  1, 0, 2'b00, 1, 0, 0,  0, 0, 0);
        vecs[27] = mk(0, 7, 1, M, 2'b00, 0, 1,  1, 1, 2'b11, 1, 0, 0,  0, 2, 1);
        vecs[28] = mk(0, 7, 0, M, 2'b00, 0, 1,  0, 0, 2'b00, 1, 0, 1,  0, 2, 1);
        vecs[29] = mk(0, 7, 0, M, 2'b00, 0, 1,  0, 0, 2'b00, 0, 1, 1,  0, 2, 1);
        // MISMATCH carrying the reference base itself
        vecs[30] = mk(1, 0, 0, M, 2'b00, 0, 1,  0, 0, 2'b00, 0, 1, 1,  0, 2, 1);
        vecs[31] = mk(0, 0, 1, X, 2'b00, 1, 1,  1, 0, 2'b00, 1, 0, 0,  0, 0, 0);
        vecs[32] = mk(0, 0, 0, M, 2'b00, 0, 1,  0, 1, 2'b00, 1, 0, CHK, 1, 1, 1);
        vecs[33] = mk(0, 0, 0, M, 2'b00, 0, 1,  0, 0, 2'b00, 0, 1, CHK, 1, 1, 1);

        rst = 1'b1;
        intf.ref_seq = 16'h1B1B;
        intf.start = 1'b0; intf.ref_start = 3'd0; intf.op_valid = 1'b0; intf.op_code = 2'b00;
        intf.op_base = 2'b00; intf.op_last = 1'b0; intf.q_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_out("reset_values", get_out(), '0);
        @(negedge clk);
        rst = 1'b0;

        apply_range(0, NVEC - 1, "tbl");

        // query overflow: seven INSERTs fill the query, the eighth faults
        drive(1, 0, 0, M, 2'b00, 0, 1);
        for (int k = 0; k < 7; k++) drive(0, 0, 1, I, 2'b01, 0, 1);
        drive(0, 0, 1, I, 2'b10, 1, 1);
        drive(0, 0, 0, M, 2'b00, 0, 1);
        #1;
        check_val("ovf_no_emit_qv", 8'(intf.q_valid), 8'd0);
        check_val("ovf_err", 8'(intf.err), 8'd1);
        check_val("ovf_busy", 8'(intf.busy), 8'd1);
        drive(0, 0, 0, M, 2'b00, 0, 1);
        #1;
        check_val("ovf_done", 8'(intf.done), 8'd1);
        check_val("ovf_q_len", 8'(intf.q_len), 8'd7);
        check_val("ovf_ldistance", intf.ldistance, 8'd7);
        check_val("ovf_score", intf.score, 8'd0);

        // asynchronous reset while a query beat is pending in RUN
        drive(1, 0, 0, M, 2'b00, 0, 1);
        drive(0, 0, 1, M, 2'b00, 0, 0);
        drive(0, 0, 0, M, 2'b00, 0, 0);
        #1;
        check_val("pre_rst_qv", 8'(intf.q_valid), 8'd1);
        #1;
        rst = 1'b1;
        #1;
        check_out("async_reset", get_out(), '0);
        @(negedge clk);
        rst = 1'b0;
        intf.q_ready = 1'b1;
        apply_range(0, 6, "rerun");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
